// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU arbiter and its benches.
//   WIDTH   : operand / result width
//   OPC_W   : opcode width (opaque to the arbiter)
//   state_t : arbiter control state
//   OP_*    : opcode values used by the attached ALU model
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPC_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OPC_W-1:0] OP_AND = 3'd4;
    localparam logic [OPC_W-1:0] OP_OR  = 3'd5;
    localparam logic [OPC_W-1:0] OP_CAT = 3'd6;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (purely combinational).
//   valid_i      : request lines, bit N = requester N
//   last_grant_i : requester granted most recently
//   grant_c_o    : one-hot grant, zero when nothing is valid
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_c_o
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_c_o = 2'b00;
        case (valid_i)
            2'b01:   grant_c_o = 2'b01;
            2'b10:   grant_c_o = 2'b10;
            2'b11:   grant_c_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_c_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   reqN_valid/ready             : request handshake (ready is combinational)
//   reqN_a/b/c/opc               : requester operands, sampled on handshake
//   alu_a/b/c/opc                : registered operands to the ALU
//   alu_w/neg/zer                : ALU result and flags
//   rsp_valid/ready              : response handshake with backpressure
//   rsp_id/w/neg/zer             : captured requester id, result and flags
//   ops_done                     : wrapping count of consumed responses
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH,
    parameter int unsigned OPC_W = alu_pkg::OPC_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_c,
    input  logic [OPC_W-1:0] req0_opc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_c,
    input  logic [OPC_W-1:0] req1_opc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c,
    output logic [OPC_W-1:0] alu_opc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_neg,
    input  logic             alu_zer,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_w,
    output logic             rsp_neg,
    output logic             rsp_zer,
    output logic [CNT_W-1:0] ops_done
);

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_id_q, grant_id_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic               alu_c_q, alu_c_d;
    logic [OPC_W-1:0]   alu_opc_q, alu_opc_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_w_q, rsp_w_d;
    logic               rsp_neg_q, rsp_neg_d;
    logic               rsp_zer_q, rsp_zer_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;
    logic [1:0]         grant_c;
    logic               sel;

    rr_arb2 u_rr_arb2 (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_c_o    (grant_c)
    );

    // Next-state and handshake logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_c_d      = alu_c_q;
        alu_opc_d    = alu_opc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_w_d      = rsp_w_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_zer_d    = rsp_zer_q;
        ops_done_d   = ops_done_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        sel          = grant_c[1];

        case (state_q)
            IDLE: begin
                // Grant is only non-zero for a valid requester, so ready
                // doubles as the handshake strobe. Held low during reset.
                req0_ready = grant_c[0] & ~rst;
                req1_ready = grant_c[1] & ~rst;
                if (grant_c != 2'b00) begin
                    alu_a_d      = sel ? req1_a   : req0_a;
                    alu_b_d      = sel ? req1_b   : req0_b;
                    alu_c_d      = sel ? req1_c   : req0_c;
                    alu_opc_d    = sel ? req1_opc : req0_opc;
                    grant_id_d   = sel;
                    last_grant_d = sel;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_w_d     = alu_w;
                rsp_neg_d   = alu_neg;
                rsp_zer_d   = alu_zer;
                rsp_id_d    = grant_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_c_q      <= 1'b0;
            alu_opc_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_w_q      <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_zer_q    <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_c_q      <= alu_c_d;
            alu_opc_q    <= alu_opc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_w_q      <= rsp_w_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_zer_q    <= rsp_zer_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_c     = alu_c_q;
    assign alu_opc   = alu_opc_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_w     = rsp_w_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_zer   = rsp_zer_q;
    assign ops_done  = ops_done_q;

endmodule
